// File: rtl/score_history_reader_pkg.sv
// Shared widths, score register range, FSM states and the double-dabble adjust step.
package score_history_reader_pkg;

    localparam int unsigned DATA_W      = 13;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned SCORE_FIRST = 1;
    localparam int unsigned SCORE_LAST  = (1 << ADDR_W) - 1;
    localparam int unsigned CNT_W       = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_CONV_BEST = 3'd2,
        ST_SHOW_RD   = 3'd3,
        ST_CONV_SHOW = 3'd4,
        ST_READY     = 3'd5
    } state_t;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_history_reader_bcd.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per cycle.
// The first iteration happens on the Go edge itself, so a conversion
// completes DATA_W edges after Go and Done pulses in the cycle that follows.
module bin_to_bcd_seq
    import score_history_reader_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Go,
    input  logic [DATA_W-1:0] Bin,
    output logic [BCD_W-1:0]  Bcd,
    output logic              Done
);

    logic [DATA_W-1:0] bin_sr;
    logic [CNT_W-1:0]  iter;
    logic              running;
    logic [BCD_W-1:0]  bcd_adj;

    assign bcd_adj = dabble_adjust(Bcd);

    // Load on Go (first iteration on all-zero digits), then adjust-and-shift per cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bin_sr  <= '0;
            iter    <= '0;
            running <= 1'b0;
            Bcd     <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Go) begin
                Bcd     <= {{(BCD_W-1){1'b0}}, Bin[DATA_W-1]};
                bin_sr  <= {Bin[DATA_W-2:0], 1'b0};
                iter    <= CNT_W'(1);
                running <= 1'b1;
            end else if (running) begin
                Bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
                bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
                iter   <= iter + CNT_W'(1);
                if (iter == CNT_W'(DATA_W - 1)) begin
                    running <= 1'b0;
                    Done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/score_history_reader.sv
// Scans stored reaction scores for the minimum and converts the best and the
// selected entry to BCD for the seven-segment decoders.
module score_history_reader
    import score_history_reader_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Next,
    input  logic [DATA_W-1:0] RunCount,
    output logic [ADDR_W-1:0] ReadAddr,
    input  logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] BestScore,
    output logic [ADDR_W-1:0] BestIndex,
    output logic [BCD_W-1:0]  BestBcd,
    output logic [ADDR_W-1:0] ShownIndex,
    output logic [BCD_W-1:0]  ShownBcd,
    output logic              Busy,
    output logic              Valid,
    output logic              Empty
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] n_reg;
    logic [DATA_W-1:0] best_val;
    logic [ADDR_W-1:0] best_idx;

    logic [ADDR_W-1:0] n_c;
    logic              take_c;
    logic [DATA_W-1:0] best_next_c;
    logic [ADDR_W-1:0] best_idx_next_c;
    logic              scan_last_c;
    logic [ADDR_W-1:0] shown_next_c;
    logic              conv_go_c;
    logic [DATA_W-1:0] conv_bin_c;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_done;

    // Entry count clamps to the number of score registers.
    assign n_c = (RunCount > DATA_W'(SCORE_LAST)) ? ADDR_W'(SCORE_LAST) : RunCount[ADDR_W-1:0];

    // First entry always loads; strict less-than keeps the lower index on ties.
    assign take_c          = (idx == ADDR_W'(SCORE_FIRST)) || (ReadData < best_val);
    assign best_next_c     = take_c ? ReadData : best_val;
    assign best_idx_next_c = take_c ? idx : best_idx;
    assign scan_last_c     = (idx == n_reg);
    assign shown_next_c    = (ShownIndex == n_reg) ? ADDR_W'(SCORE_FIRST)
                                                   : ShownIndex + ADDR_W'(1);

    // Converter starts on the final scan edge (with the final best) and on the SHOW_RD edge.
    assign conv_go_c  = ((state == ST_SCAN) && scan_last_c) || (state == ST_SHOW_RD);
    assign conv_bin_c = (state == ST_SCAN) ? best_next_c : ReadData;

    bin_to_bcd_seq u_bcd (
        .Clock (Clock),
        .Reset (Reset),
        .Go    (conv_go_c),
        .Bin   (conv_bin_c),
        .Bcd   (conv_bcd),
        .Done  (conv_done)
    );

    // Control FSM with index counter, best-compare registers and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            n_reg      <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            ReadAddr   <= '0;
            BestScore  <= '0;
            BestIndex  <= '0;
            BestBcd    <= '0;
            ShownIndex <= '0;
            ShownBcd   <= '0;
            Busy       <= 1'b0;
            Valid      <= 1'b0;
            Empty      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_READY: begin
                    if (Start) begin
                        n_reg <= n_c;
                        Valid <= 1'b0;
                        if (n_c == '0) begin
                            state      <= ST_READY;
                            Empty      <= 1'b1;
                            Busy       <= 1'b0;
                            ReadAddr   <= '0;
                            BestScore  <= '0;
                            BestIndex  <= '0;
                            BestBcd    <= '0;
                            ShownIndex <= '0;
                            ShownBcd   <= '0;
                        end else begin
                            state    <= ST_SCAN;
                            Empty    <= 1'b0;
                            Busy     <= 1'b1;
                            idx      <= ADDR_W'(SCORE_FIRST);
                            ReadAddr <= ADDR_W'(SCORE_FIRST);
                        end
                    end else if (state == ST_READY) begin
                        Valid <= 1'b1;
                        if (Next && !Empty) begin
                            ShownIndex <= shown_next_c;
                            ReadAddr   <= shown_next_c;
                            Valid      <= 1'b0;
                            Busy       <= 1'b1;
                            state      <= ST_SHOW_RD;
                        end
                    end
                end
                ST_SCAN: begin
                    best_val <= best_next_c;
                    best_idx <= best_idx_next_c;
                    if (scan_last_c) begin
                        BestScore <= best_next_c;
                        BestIndex <= best_idx_next_c;
                        state     <= ST_CONV_BEST;
                    end else begin
                        idx      <= idx + ADDR_W'(1);
                        ReadAddr <= idx + ADDR_W'(1);
                    end
                end
                ST_CONV_BEST: begin
                    if (conv_done) begin
                        BestBcd    <= conv_bcd;
                        ShownIndex <= ADDR_W'(SCORE_FIRST);
                        ReadAddr   <= ADDR_W'(SCORE_FIRST);
                        state      <= ST_SHOW_RD;
                    end
                end
                ST_SHOW_RD: begin
                    state <= ST_CONV_SHOW;
                end
                ST_CONV_SHOW: begin
                    if (conv_done) begin
                        ShownBcd <= conv_bcd;
                        Valid    <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= ST_READY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
